tiny_alu_param: RTL
===================

Name: tiny_alu_param

Overview:
- Next-generation tiny ALU: data width is a parameter, valid/ready handshakes replace the fixed start/done pair, and MUL is a multi-cycle sequential operation.
- Sits between a transaction driver (upstream) and a result consumer (downstream) in the tiny_alu testbench architecture.
- One operation in flight at a time; a single-entry output register holds the result under backpressure.

Parameters:
- DATA_W, 8, operand width in bits; legal range 2..32.
- RES_W, 2*DATA_W, result width; derived, not overridable.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- op  in  3  opcode, values from tiny_alu_param_pkg.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  RES_W  result.
- err  out  1  illegal-opcode flag, qualified by out_valid.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system):
  - state=IDLE; out_valid=0; result=0; err=0; multiplier cleared.
  - in_ready=0 while reset is high.
  - Reset mid-MUL aborts the operation with no output.
- Opcodes:
  - NOP=0: result=0.
  - ADD=1: zero-extended a+b; carry lands in bit DATA_W.
  - AND=2: zero-extended a&b.
  - XOR=3: zero-extended a^b.
  - MUL=4: unsigned a*b, full RES_W width.
  - 5..7: illegal.
- Accept: transfer occurs on the edge where in_valid && in_ready. Operands are latched; later input changes are ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A result drain and a new accept can happen on the same edge.
- FSM states: IDLE, MUL.
  - IDLE, accept with op!=MUL: result and err loaded on the accepting edge; out_valid=1 on the next cycle (1-cycle latency); stay in IDLE.
  - IDLE, accept with MUL: go to MUL; load the multiplier sub-module; cnt=0.
  - MUL: one shift-add step per cycle. After DATA_W steps, load the result register, set out_valid, return to IDLE. out_valid rises DATA_W cycles after the accepting edge. in_ready=0 throughout.
- Output: out_valid, result and err hold stable until out_valid && out_ready. On that edge, out_valid clears unless a new single-cycle result loads on the same edge.
- Back-to-back single-cycle operations with out_ready=1 sustain 1 op/cycle.

Optional Feature:
- Macro: TINY_ALU_PARAM_ILLEGAL_OP_ERR_EN.
- Defined: illegal opcodes complete in 1 cycle with result=0 and err=1.
- Undefined: illegal opcodes behave as NOP (result=0) and err is tied 0.
- The port list is identical in both builds.

Decomposition:
- Package tiny_alu_param_pkg holds:
  - OPCODE_BITS=3 and the NOP/ADD/AND/XOR/MUL opcode constants.
  - An enum typedef op_e.
  - A state enum state_e {IDLE, MUL}.
- Sub-module tiny_alu_param_mul_seq: shift-add unsigned multiplier.
  - Ports: clk, reset, load, a, b, busy, done, product.
  - Takes DATA_W cycles from load to done.
- Top level holds the FSM, the single-cycle datapath and the output register.

Test Plan (DATA_W=8):
- ADD a=0xFF, b=0x01, out_ready=1 -> out_valid one cycle after accept, result=0x0100, err=0. XOR 0xA5^0x0F -> 0x00AA. AND 0xF0&0x3C -> 0x0030.
- MUL a=0xFF, b=0xFF -> in_ready=0 for 8 cycles, out_valid 8 cycles after accept, result=0xFE01. MUL 0x00*0x7F -> 0x0000.
- Stream of 4 ADDs with in_valid held and out_ready=1 -> one result per cycle, in order, no bubbles.
- Hold out_ready=0 after an ADD result -> in_ready=0, result and out_valid frozen. Raise out_ready -> drain, with a same-edge accept of the next op.
- Assert reset at cycle 4 of a MUL -> out_valid=0 and result=0 immediately (asynchronously). After release, in_ready=1 and no stale result appears.
- op=7, a=0x12, b=0x34:
  - With the macro defined -> result=0, err=1, 1-cycle latency.
  - Without the macro -> result=0, err=0.

Source files
------------

// File: rtl/tiny_alu_param_pkg.sv
// Shared opcode and FSM-state definitions for tiny_alu_param.
// Opcodes 5..7 are illegal; see TINY_ALU_PARAM_ILLEGAL_OP_ERR_EN in the top for how they report.
package tiny_alu_param_pkg;

    localparam int OPCODE_BITS = 3;

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/tiny_alu_param_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, DATA_W steps per load.
// done marks the cycle of the final step; product is the completed product while done is high.
module tiny_alu_param_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W);

    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic [RES_W-1:0]  acc_next;

    // The last partial product is folded in combinationally so the top can
    // capture the full product on the same edge that ends the final step.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign done     = busy && (cnt == CNT_W'(DATA_W - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tiny_alu_param.sv
// Tiny ALU with valid/ready handshakes, single-cycle NOP/ADD/AND/XOR and a DATA_W-cycle MUL.
// Build option: define TINY_ALU_PARAM_ILLEGAL_OP_ERR_EN to flag opcodes 5..7 with err=1.
module tiny_alu_param
    import tiny_alu_param_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       a,
    input  logic [DATA_W-1:0]       b,
    input  logic [OPCODE_BITS-1:0]  op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_W-1:0]     result,
    output logic                    err
);

    localparam int RES_W = 2 * DATA_W;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; the sender holds its payload until then, and the receiver's
    // ready never depends on its own valid.
    state_e             state;
    state_e             next_state;
    logic               accept;
    logic               is_mul;
    logic [DATA_W:0]    sum;
    logic [RES_W-1:0]   alu_res;
    logic               alu_err;
    logic               mul_busy;
    logic               mul_done;
    logic [RES_W-1:0]   mul_product;

    assign is_mul   = (op == OP_MUL);
    assign in_ready = !reset && (state == IDLE) && !mul_busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, a} + {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            OP_NOP: alu_res = '0;
            OP_ADD: alu_res = {{(RES_W-DATA_W-1){1'b0}}, sum};
            OP_AND: alu_res = {{DATA_W{1'b0}}, a & b};
            OP_XOR: alu_res = {{DATA_W{1'b0}}, a ^ b};
            OP_MUL: alu_res = '0;
            default: begin
                alu_res = '0;
`ifdef TINY_ALU_PARAM_ILLEGAL_OP_ERR_EN
                alu_err = 1'b1;
`else
                alu_err = 1'b0;
`endif
            end
        endcase
    end

    tiny_alu_param_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (accept && is_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && is_mul) next_state = MUL;
            MUL:     if (mul_done)         next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A new single-cycle result may load on the same edge the old one drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
        end else if (accept && !is_mul) begin
            result    <= alu_res;
            err       <= alu_err;
            out_valid <= 1'b1;
        end else if (mul_done) begin
            result    <= mul_product;
            err       <= 1'b0;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
